// File: rtl/aes_round_key_cache.sv
// Expands one AES-128 key through an external key memory and buffers all round keys for indexed reads.
// Latency: keys_ready 12+KM_LAT edges after key accept; rd_key is registered, 1 cycle after rd_round.
// Backpressure: key_ready is low from accept until the buffer is complete; key_valid is ignored meanwhile.
module aes_round_key_cache #(
    parameter int KM_LAT  = 1,
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [3:0]   km_times,
    output logic [127:0] km_key,
    input  logic [127:0] km_keyout,
    output logic         keys_ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    typedef enum logic [2:0] {IDLE, LOAD, GEN, DRAIN, READY} state_t;

    localparam logic [3:0] LAST      = 4'(NROUNDS);
    localparam int         DRAIN_END = (KM_LAT > 0) ? KM_LAT - 1 : 0;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     drain_cnt;
    logic [3:0]     km_times_nxt;
    logic           key_ready_nxt;
    logic           keys_ready_nxt;
    logic           accept;
    logic           cap_vld;
    logic [3:0]     cap_idx;
    logic [127:0]   rk [NROUNDS+1];

    assign accept = key_valid & key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            km_times   <= '0;
            key_ready  <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= (state == DRAIN && state_nxt == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            km_times   <= km_times_nxt;
            key_ready  <= key_ready_nxt;
            keys_ready <= keys_ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = GEN;
            GEN:     if (km_times == LAST) state_nxt = (KM_LAT == 0) ? READY : DRAIN;
            DRAIN:   if (drain_cnt == 2'(DRAIN_END)) state_nxt = READY;
            READY:   if (accept) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready flags rise one edge after READY entry so the last capture has landed before anyone reads.
    always_comb begin
        km_times_nxt   = '0;
        key_ready_nxt  = 1'b0;
        keys_ready_nxt = 1'b0;
        case (state_nxt)
            GEN:     km_times_nxt = (state == LOAD) ? 4'd1 : km_times + 4'd1;
            DRAIN:   km_times_nxt = LAST;
            default: km_times_nxt = '0;
        endcase
        keys_ready_nxt = (state == READY) && (state_nxt == READY);
        key_ready_nxt  = (state_nxt == IDLE) || keys_ready_nxt;
    end

    generate
        if (KM_LAT == 0) begin : g_comb
            assign cap_vld = (km_times != 4'd0);
            assign cap_idx = km_times;
        end else begin : g_pipe
            logic [KM_LAT-1:0] tag_vld;
            logic [3:0]        tag_idx [KM_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < KM_LAT; i++) begin
                        tag_vld[i] <= 1'b0;
                        tag_idx[i] <= '0;
                    end
                end else begin
                    tag_vld[0] <= (km_times != 4'd0);
                    tag_idx[0] <= km_times;
                    for (int i = 1; i < KM_LAT; i++) begin
                        tag_vld[i] <= tag_vld[i-1];
                        tag_idx[i] <= tag_idx[i-1];
                    end
                end
            end

            assign cap_vld = tag_vld[KM_LAT-1];
            assign cap_idx = tag_idx[KM_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            km_key <= '0;
            rd_key <= '0;
            for (int i = 0; i <= NROUNDS; i++) rk[i] <= '0;
        end else begin
            if (accept) begin
                km_key <= key_in;
                rk[0]  <= key_in;
            end
            if (cap_vld) rk[cap_idx] <= km_keyout;
            rd_key <= (rd_round <= LAST) ? rk[rd_round] : '0;
        end
    end

endmodule

// File: tb/tb_aes_round_key_cache.sv
// Bench: three caches (KM_LAT 1, 0, 3) each fed by a behavioural AES-128 key memory.
module tb_aes_round_key_cache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in    [3];
    logic [2:0]   key_valid;
    logic [2:0]   key_ready;
    logic [3:0]   km_times  [3];
    logic [127:0] km_key    [3];
    logic [127:0] km_keyout [3];
    logic [2:0]   keys_ready;
    logic [3:0]   rd_round  [3];
    logic [127:0] rd_key    [3];

    logic [7:0]   sbox_t [256];
    int           vectors;
    int           miscompares;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Straight FIPS-197 key schedule; returns round key r of key.
    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        if (r < 0 || r > 10) return '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        logic [127:0] rkm  [11];
        logic [127:0] pipe [4];

        always @(km_key[g]) begin
            for (int r = 0; r < 11; r++) rkm[r] = round_key(km_key[g], r);
        end

        always @(posedge clk) begin
            pipe[0] <= (km_times[g] <= 4'd10) ? rkm[km_times[g]] : '0;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        if (L == 0) begin : c
            assign km_keyout[g] = (km_times[g] <= 4'd10) ? rkm[km_times[g]] : '0;
        end else begin : p
            assign km_keyout[g] = pipe[L-1];
        end

        aes_round_key_cache #(.KM_LAT(L), .NROUNDS(10)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (key_in[g]),
            .key_valid  (key_valid[g]),
            .key_ready  (key_ready[g]),
            .km_times   (km_times[g]),
            .km_key     (km_key[g]),
            .km_keyout  (km_keyout[g]),
            .keys_ready (keys_ready[g]),
            .rd_round   (rd_round[g]),
            .rd_key     (rd_key[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for key_ready, then presents k for exactly one accept edge.
    task automatic send(input int g, input logic [127:0] k);
        int n = 0;
        while (!key_ready[g] && n < 50) begin
            tick();
            n++;
        end
        chk("send_key_ready", 128'(key_ready[g]), 128'd1);
        key_in[g]    = k;
        key_valid[g] = 1'b1;
        tick();
        key_valid[g] = 1'b0;
    endtask

    // n = edges already elapsed since the accept edge.
    task automatic wait_ready(input int g, input int exp_edge, input int start);
        int n = start;
        while (!keys_ready[g] && n < 40) begin
            tick();
            n++;
        end
        chk("keys_ready_edge", 128'(n), 128'(exp_edge));
    endtask

    task automatic sweep(input int g, input logic [127:0] k, input bit zero);
        for (int r = 0; r < 16; r++) begin
            rd_round[g] = 4'(r);
            tick();
            chk("sweep_rd_key", rd_key[g], zero ? 128'd0 : round_key(k, r));
        end
    endtask

    initial begin
        logic [127:0] ka, kb, kc;
        int n;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv = 8'h00;
            if (i != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(i));
            end
            sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int g = 0; g < 3; g++) begin
            key_in[g]   = '0;
            rd_round[g] = '0;
        end
        key_valid = '0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready[0]), 128'd0);
        chk("rst_keys_ready", 128'(keys_ready[0]), 128'd0);
        chk("rst_km_times", 128'(km_times[0]), 128'd0);
        chk("rst_km_key", km_key[0], 128'd0);
        chk("rst_rd_key", rd_key[0], 128'd0);
        rst_n = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) chk("idle_key_ready", 128'(key_ready[g]), 128'd1);

        send(0, FIPS_KEY);
        chk("fips_km_key", km_key[0], FIPS_KEY);
        for (int t = 0; t <= 10; t++) begin
            chk("km_times_seq", 128'(km_times[0]), 128'(t));
            chk("busy_key_ready", 128'(key_ready[0]), 128'd0);
            tick();
        end
        wait_ready(0, 13, 11);
        rd_round[0] = 4'd10;
        tick();
        chk("fips_round10", rd_key[0], FIPS_R10);
        rd_round[0] = 4'd0;
        tick();
        chk("fips_round0", rd_key[0], FIPS_KEY);
        sweep(0, FIPS_KEY, 1'b0);

        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        send(0, ka);
        repeat (3) tick();
        key_in[0]    = kb;
        key_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_key_ready", 128'(key_ready[0]), 128'd0);
            chk("bp_km_key", km_key[0], ka);
            tick();
        end
        n = 0;
        while (!keys_ready[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp_keys_ready", 128'(keys_ready[0]), 128'd1);
        tick();
        key_valid[0] = 1'b0;
        chk("bp_drop_keys_ready", 128'(keys_ready[0]), 128'd0);
        chk("bp_second_key", km_key[0], kb);
        wait_ready(0, 13, 0);
        sweep(0, kb, 1'b0);

        repeat (2) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            send(0, ka);
            wait_ready(0, 13, 0);
            sweep(0, ka, 1'b0);
        end

        kc = {$urandom, $urandom, $urandom, $urandom};
        send(0, kc);
        n = 0;
        while (km_times[0] != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_km_times", 128'(km_times[0]), 128'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_keys_ready", 128'(keys_ready[0]), 128'd0);
        chk("mid_key_ready", 128'(key_ready[0]), 128'd0);
        chk("mid_km_times_clr", 128'(km_times[0]), 128'd0);
        chk("mid_km_key", km_key[0], 128'd0);
        chk("mid_rd_key", rd_key[0], 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        sweep(0, '0, 1'b1);
        kc = {$urandom, $urandom, $urandom, $urandom};
        send(0, kc);
        wait_ready(0, 13, 0);
        sweep(0, kc, 1'b0);

        send(1, FIPS_KEY);
        wait_ready(1, 12, 0);
        sweep(1, FIPS_KEY, 1'b0);
        send(2, FIPS_KEY);
        wait_ready(2, 15, 0);
        sweep(2, FIPS_KEY, 1'b0);
        for (int g = 1; g < 3; g++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            send(g, ka);
            wait_ready(g, (g == 1) ? 12 : 15, 0);
            sweep(g, ka, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
